// File: rtl/fc_argmax_seq_if.sv
// Handshake bundle between the final fully-connected layer, the argmax
// back-end and whatever consumes the classification result.
//
// Signals:
//   in_valid / in_ready   score-vector handshake (producer -> back-end)
//   scores_in             OC packed signed Q8.8 scores, score k at [16k+15:16k]
//   out_valid / out_ready result handshake (back-end -> consumer)
//   out_class             index of the winning score
//   out_score             winning signed Q8.8 score
//   out_margin            unsigned distance from winner to runner-up
//
// Modports:
//   master  drives the vector and accepts the result (upstream/downstream side)
//   slave   the argmax back-end itself
interface fc_argmax_seq_if #(
  parameter int OC   = 10,
  parameter int IDXW = $clog2(OC)
);
  logic              in_valid;
  logic              in_ready;
  logic [OC*16-1:0]  scores_in;
  logic              out_valid;
  logic              out_ready;
  logic [IDXW-1:0]   out_class;
  logic [15:0]       out_score;
  logic [16:0]       out_margin;

  modport master (
    output in_valid, scores_in, out_ready,
    input  in_ready, out_valid, out_class, out_score, out_margin
  );

  modport slave (
    input  in_valid, scores_in, out_ready,
    output in_ready, out_valid, out_class, out_score, out_margin
  );
endinterface

// File: rtl/fc_argmax_seq.sv
// Sequential argmax back-end for the classifier's final FC layer.
// A score vector is latched in one handshake, then scanned one score per
// cycle keeping the best and second-best values. The winner's index, its
// score and the margin to the runner-up are presented and held until the
// consumer accepts them.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fc_argmax_seq_if.slave (vector in, result out)
module fc_argmax_seq #(
  parameter int OC   = 10,
  parameter int IDXW = $clog2(OC)
) (
  input  logic          clk,
  input  logic          rst_n,
  fc_argmax_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t              state;
  logic signed [15:0]  scores [OC];
  logic signed [15:0]  best;
  logic signed [15:0]  second;
  logic [IDXW-1:0]     idx;
  logic [IDXW-1:0]     scan_idx;

  logic signed [15:0]  cur;
  logic signed [15:0]  best_nxt;
  logic signed [15:0]  second_nxt;
  logic [IDXW-1:0]     idx_nxt;
  logic [16:0]         margin_nxt;

  // One compare step of the scan. Strict greater-than keeps the lowest
  // index on ties and lets an equal value fall through to become the
  // runner-up, which yields a zero margin for duplicated maxima.
  always_comb begin
    cur        = scores[scan_idx];
    best_nxt   = best;
    second_nxt = second;
    idx_nxt    = idx;
    if (cur > best) begin
      second_nxt = best;
      best_nxt   = cur;
      idx_nxt    = scan_idx;
    end else if (cur > second) begin
      second_nxt = cur;
    end
  end

  // The margin is taken from the post-compare values so the last score
  // of the vector is included. Sign-extending both operands to 17 bits
  // makes the full range (up to 65535) representable without overflow.
  always_comb begin
    margin_nxt = {best_nxt[15], best_nxt} - {second_nxt[15], second_nxt};
  end

  // Control FSM with registered handshake and result outputs. The result
  // fields are only written on entry to DONE, so they keep their value
  // after handoff until the next vector finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_class  <= '0;
      bus.out_score  <= '0;
      bus.out_margin <= '0;
      best           <= '0;
      second         <= '0;
      idx            <= '0;
      scan_idx       <= '0;
      for (int k = 0; k < OC; k++) begin
        scores[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < OC; k++) begin
              scores[k] <= bus.scores_in[16*k +: 16];
            end
            best         <= bus.scores_in[15:0];
            second       <= 16'sh8000;
            idx          <= '0;
            scan_idx     <= IDXW'(1);
            bus.in_ready <= 1'b0;
            state        <= SCAN;
          end
        end

        SCAN: begin
          best   <= best_nxt;
          second <= second_nxt;
          idx    <= idx_nxt;
          if (scan_idx == IDXW'(OC - 1)) begin
            bus.out_class  <= idx_nxt;
            bus.out_score  <= best_nxt;
            bus.out_margin <= margin_nxt;
            bus.out_valid  <= 1'b1;
            state          <= DONE;
          end else begin
            scan_idx <= scan_idx + IDXW'(1);
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
